lipsi_io_port: RTL and testbench

Parametrised multi-channel I/O port for the Lipsi processor, replacing the single fixed 8-bit `io_in`/`io_out` pair with CH channels of W bits each. The processor reaches all channels through one register-mapped bus with a one-cycle acknowledge. Each input is synchronised and has a sticky change-detect flag. Output channels are held in registers. The block sits between the processor core and the chip pins.

---
 rtl/lipsi_io_port_if.sv | 24 ++
 rtl/lipsi_io_port.sv | 107 ++++++++++
 tb/tb_lipsi_io_port.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/lipsi_io_port_if.sv
// Register bus between the Lipsi core and lipsi_io_port.
//   bus_addr  : register address
//   bus_wr    : one-cycle write strobe
//   bus_rd    : one-cycle read strobe
//   bus_wdata : write data
//   bus_rdata : read data, valid while bus_ack=1, 0 otherwise
//   bus_ack   : one-cycle acknowledge for every accepted access
// master = processor side, slave = I/O port side.
interface lipsi_io_port_if #(
  parameter int W  = 8,
  parameter int AW = 4
);
  logic [AW-1:0] bus_addr;
  logic          bus_wr;
  logic          bus_rd;
  logic [W-1:0]  bus_wdata;
  logic [W-1:0]  bus_rdata;
  logic          bus_ack;

  modport master (output bus_addr, bus_wr, bus_rd, bus_wdata,
                  input  bus_rdata, bus_ack);
  modport slave  (input  bus_addr, bus_wr, bus_rd, bus_wdata,
                  output bus_rdata, bus_ack);
endinterface

// File: rtl/lipsi_io_port.sv
// Multi-channel I/O port for the Lipsi processor.
//   CH input channels of W bits (two-flop synchronised, sticky change flags)
//   and CH registered output channels, reached through one register bus.
// Address map: 0..CH-1 channel data, CH status (read clears flags),
//   CH+1 irq mask (only with LIPSI_IO_IRQ_EN), everything else reads 0.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   bus          : lipsi_io_port_if slave (addr/wr/rd/wdata/rdata/ack)
//   io_in        : CH*W pin inputs, channel k at [k*W +: W], async to clk
//   io_out       : CH*W registered pin outputs, same packing
//   irq          : registered interrupt, only with LIPSI_IO_IRQ_EN
// Optional feature macro: LIPSI_IO_IRQ_EN (mask register + irq port).
// Timing: strobe sampled at edge n -> writes land at edge n, data/status are
// captured and flags cleared at edge n+1 where bus_ack rises.
module lipsi_io_port #(
  parameter int W  = 8,
  parameter int CH = 4,
  parameter int AW = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  lipsi_io_port_if.slave    bus,
  input  logic [CH*W-1:0]   io_in,
`ifdef LIPSI_IO_IRQ_EN
  output logic              irq,
`endif
  output logic [CH*W-1:0]   io_out
);

  logic [CH-1:0][W-1:0] s1, s2, p, out_r;
  logic [CH-1:0]        chg, flags;
  logic                 acc_q, rd_q;
  logic [AW-1:0]        addr_q;
  logic [W-1:0]         rdata_nxt;
  logic                 stat_rd;

  assign io_out = out_r;

  for (genvar k = 0; k < CH; k++) begin : g_chg
    assign chg[k] = (s2[k] != p[k]);
  end

`ifdef LIPSI_IO_IRQ_EN
  logic [CH-1:0] mask;
`endif

  // Status read consumes the flags on the ack edge.
  assign stat_rd = rd_q && (addr_q == AW'(CH));

  always_comb begin
    rdata_nxt = '0;
    if (rd_q) begin
      for (int k = 0; k < CH; k++)
        if (addr_q == AW'(k)) rdata_nxt = s2[k];
      if (addr_q == AW'(CH)) rdata_nxt = W'(flags);
`ifdef LIPSI_IO_IRQ_EN
      if (addr_q == AW'(CH + 1)) rdata_nxt = W'(mask);
`endif
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1            <= '0;
      s2            <= '0;
      p             <= '0;
      out_r         <= '0;
      flags         <= '0;
      acc_q         <= 1'b0;
      rd_q          <= 1'b0;
      addr_q        <= '0;
      bus.bus_ack   <= 1'b0;
      bus.bus_rdata <= '0;
`ifdef LIPSI_IO_IRQ_EN
      mask          <= '0;
      irq           <= 1'b0;
`endif
    end else begin
      s1 <= io_in;
      s2 <= s1;
      p  <= s2;

      // Set wins over a same-cycle clear.
      flags <= stat_rd ? chg : (flags | chg);

      if (bus.bus_wr) begin
        for (int k = 0; k < CH; k++)
          if (bus.bus_addr == AW'(k)) out_r[k] <= bus.bus_wdata;
`ifdef LIPSI_IO_IRQ_EN
        if (bus.bus_addr == AW'(CH + 1)) mask <= bus.bus_wdata[CH-1:0];
`endif
      end

      // A read issued together with a write is dropped, not the write.
      acc_q  <= bus.bus_wr | bus.bus_rd;
      rd_q   <= bus.bus_rd & ~bus.bus_wr;
      addr_q <= bus.bus_addr;

      bus.bus_ack   <= acc_q;
      bus.bus_rdata <= rdata_nxt;
`ifdef LIPSI_IO_IRQ_EN
      irq <= |(flags & mask);
`endif
    end
  end

endmodule

// File: tb/tb_lipsi_io_port.sv
module tb_lipsi_io_port;
  localparam int W  = 8;
  localparam int CH = 4;
  localparam int AW = 4;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic [CH*W-1:0] io_in;
  logic [CH*W-1:0] io_out;
`ifdef LIPSI_IO_IRQ_EN
  logic            irq;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lipsi_io_port_if #(.W(W), .AW(AW)) bus ();

  lipsi_io_port #(.W(W), .CH(CH), .AW(AW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus),
    .io_in   (io_in),
`ifdef LIPSI_IO_IRQ_EN
    .irq     (irq),
`endif
    .io_out  (io_out)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Read: strobe sampled at edge n, ack/data after edge n+1, idle after n+2.
  task automatic rd(input string tag, input logic [AW-1:0] a, input logic [W-1:0] exp);
    bus.bus_addr = a;
    bus.bus_rd   = 1'b1;
    tick();
    bus.bus_rd   = 1'b0;
    chk({tag, "_ack_early"}, 32'(bus.bus_ack), 32'd0);
    tick();
    chk({tag, "_ack"}, 32'(bus.bus_ack), 32'd1);
    chk(tag, 32'(bus.bus_rdata), 32'(exp));
    tick();
    chk({tag, "_ack_end"}, 32'(bus.bus_ack), 32'd0);
    chk({tag, "_rdata_idle"}, 32'(bus.bus_rdata), 32'd0);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [W-1:0] d);
    bus.bus_addr  = a;
    bus.bus_wdata = d;
    bus.bus_wr    = 1'b1;
    tick();
    bus.bus_wr    = 1'b0;
    tick();
    chk("wr_ack", 32'(bus.bus_ack), 32'd1);
    tick();
  endtask

  initial begin
    bus.bus_addr  = '0;
    bus.bus_wr    = 1'b0;
    bus.bus_rd    = 1'b0;
    bus.bus_wdata = '0;
    io_in         = '0;

    // Reset state
    tick(); tick();
    chk("rst_io_out", io_out, 32'h0);
    chk("rst_ack", 32'(bus.bus_ack), 32'd0);
    chk("rst_rdata", 32'(bus.bus_rdata), 32'd0);
    reset_n = 1'b1;
    tick();
    rd("rd_ch0_init", 4'd0, 8'h00);

    // Back-to-back writes to channels 2 and 3
    bus.bus_addr = 4'd2; bus.bus_wdata = 8'hA5; bus.bus_wr = 1'b1;
    tick();
    chk("b2b_ch2", 32'(io_out[23:16]), 32'hA5);
    chk("b2b_ack_n", 32'(bus.bus_ack), 32'd0);
    bus.bus_addr = 4'd3; bus.bus_wdata = 8'h3C;
    tick();
    bus.bus_wr = 1'b0;
    chk("b2b_ack1", 32'(bus.bus_ack), 32'd1);
    chk("b2b_ch3", 32'(io_out[31:24]), 32'h3C);
    tick();
    chk("b2b_ack2", 32'(bus.bus_ack), 32'd1);
    tick();
    chk("b2b_ack_end", 32'(bus.bus_ack), 32'd0);
    chk("b2b_ch01", 32'(io_out[15:0]), 32'h0000);

    // Channel 1 input change; status read whose clear meets the flag set
    io_in[15:8] = 8'hF0;
    tick();
    rd("stat_early", 4'(CH), 8'h00);
    rd("rd_ch1", 4'd1, 8'hF0);
    rd("stat_ch1", 4'(CH), 8'h02);
    rd("stat_clr", 4'(CH), 8'h00);

    // Channel 0 toggles as a status read is sampled
    io_in[7:0] = 8'h01;
    rd("stat_prior", 4'(CH), 8'h00);
    rd("stat_ch0", 4'(CH), 8'h01);
    rd("stat_ch0_clr", 4'(CH), 8'h00);

    // Simultaneous write and read: write wins, rdata 0
    bus.bus_addr = 4'd1; bus.bus_wdata = 8'h55;
    bus.bus_wr = 1'b1; bus.bus_rd = 1'b1;
    tick();
    bus.bus_wr = 1'b0; bus.bus_rd = 1'b0;
    chk("wrrd_ch1", 32'(io_out[15:8]), 32'h55);
    chk("wrrd_ack_n", 32'(bus.bus_ack), 32'd0);
    tick();
    chk("wrrd_ack", 32'(bus.bus_ack), 32'd1);
    chk("wrrd_rdata", 32'(bus.bus_rdata), 32'd0);
    tick();
    chk("wrrd_ack_end", 32'(bus.bus_ack), 32'd0);

    rd("rd_unmapped", 4'hF, 8'h00);
    wr(4'hF, 8'hFF);
    chk("unmapped_wr_out", io_out, 32'h3CA5_5500);

    // Mask register (unmapped without the irq feature)
    wr(4'(CH + 1), 8'h04);
`ifdef LIPSI_IO_IRQ_EN
    rd("rd_mask", 4'(CH + 1), 8'h04);
    chk("irq_idle", 32'(irq), 32'd0);
    io_in[23:16] = 8'h11;
    tick(); tick(); tick();
    chk("irq_at_flag", 32'(irq), 32'd0);
    tick();
    chk("irq_rise", 32'(irq), 32'd1);
    rd("stat_irq", 4'(CH), 8'h04);
    chk("irq_fall", 32'(irq), 32'd0);
    io_in[7:0] = 8'h00;
    tick(); tick(); tick(); tick(); tick();
    chk("irq_masked", 32'(irq), 32'd0);
    rd("stat_ch0_masked", 4'(CH), 8'h01);
`else
    rd("rd_mask_unmapped", 4'(CH + 1), 8'h00);
`endif

    // Reset mid-access
    bus.bus_addr = 4'd0; bus.bus_rd = 1'b1;
    tick();
    bus.bus_rd = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk("rst_mid_out", io_out, 32'h0);
    chk("rst_mid_ack", 32'(bus.bus_ack), 32'd0);
    chk("rst_mid_rdata", 32'(bus.bus_rdata), 32'd0);
`ifdef LIPSI_IO_IRQ_EN
    chk("rst_mid_irq", 32'(irq), 32'd0);
`endif
    tick();
    chk("rst_mid_noack", 32'(bus.bus_ack), 32'd0);
    reset_n = 1'b1;
    tick(); tick(); tick(); tick();
    // Nonzero pins at release flag once
`ifdef LIPSI_IO_IRQ_EN
    rd("stat_after_rst", 4'(CH), 8'h06);
`else
    rd("stat_after_rst", 4'(CH), 8'h03);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
